// File: rtl/emif_bringup_sequencer.sv
// Board bring-up sequencer: clock-gen release, EMIF reset pulse,
// calibration wait with retry/timeout, core reset release, sticky fail.
//
// Ports:
//   clk, reset_n        board clock, async active-low reset
//   restart             pulse, honoured in RUN or FAIL only
//   cal_success/fail    per-channel EMIF calibration status (async)
//   clkgen_rst_n/oe_n   SI5340 reset / output-enable
//   emif_reset_req      per-channel EMIF local reset request
//   sys_reset_n         core/QSYS reset
//   state_o, retry_cnt, fail   status
module emif_bringup_sequencer #(
  parameter int NUM_CHANNELS = 1,
  parameter logic [NUM_CHANNELS-1:0] CHANNEL_MASK = '1,
  parameter int NUM_CLKGEN = 2,
  parameter int CLK_SETTLE = 50000,
  parameter int RESET_PULSE = 64,
  parameter int CAL_TIMEOUT = 2**24,
  parameter int MAX_RETRIES = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    restart,
  input  logic [NUM_CHANNELS-1:0] cal_success,
  input  logic [NUM_CHANNELS-1:0] cal_fail,
  output logic [NUM_CLKGEN-1:0]   clkgen_rst_n,
  output logic [NUM_CLKGEN-1:0]   clkgen_oe_n,
  output logic [NUM_CHANNELS-1:0] emif_reset_req,
  output logic                    sys_reset_n,
  output logic [2:0]              state_o,
  output logic [3:0]              retry_cnt,
  output logic                    fail
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_RST    = 3'd2,
    S_CAL    = 3'd3,
    S_RUN    = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam logic [24:0] SETTLE_LAST = 25'(CLK_SETTLE - 1);
  localparam logic [24:0] PULSE_LAST  = 25'(RESET_PULSE - 1);
  localparam logic [24:0] TO_LAST     = 25'(CAL_TIMEOUT - 1);
  localparam logic [3:0]  MAX_R       = 4'(MAX_RETRIES);

  typedef logic [NUM_CHANNELS-1:0] ch_t;

  ch_t [SYNC_STAGES-1:0] s_sync;
  ch_t [SYNC_STAGES-1:0] f_sync;
  ch_t                   s_v;
  ch_t                   f_v;

  state_t      state;
  state_t      state_n;
  state_t      ret_state;
  logic [24:0] cnt;
  logic [3:0]  retry_n;
  logic [3:0]  ret_cnt;
  logic        can_retry;
  logic        fail_ev;
  logic        clk_on;
  ch_t         emif_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_sync <= '0;
      f_sync <= '0;
    end else begin
      s_sync <= {s_sync[SYNC_STAGES-2:0], cal_success};
      f_sync <= {f_sync[SYNC_STAGES-2:0], cal_fail};
    end
  end

  assign s_v = s_sync[SYNC_STAGES-1] & CHANNEL_MASK;
  assign f_v = f_sync[SYNC_STAGES-1] & CHANNEL_MASK;

  assign can_retry = retry_cnt < MAX_R;
  assign ret_state = can_retry ? S_RST : S_FAIL;
  assign ret_cnt   = can_retry ? retry_cnt + 4'd1 : retry_cnt;
  assign fail_ev   = (f_v != '0) || (cnt == TO_LAST);

  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    unique case (state)
      S_IDLE: state_n = S_SETTLE;
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) state_n = S_RST;
      end
      S_RST: begin
        if (cnt == PULSE_LAST) state_n = S_CAL;
      end
      S_CAL: begin
        if (fail_ev) begin
          state_n = ret_state;
          retry_n = ret_cnt;
        end else if (s_v == CHANNEL_MASK) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (restart) begin
          state_n = S_RST;
          retry_n = '0;
        end else if (s_v != CHANNEL_MASK || f_v != '0) begin
          state_n = ret_state;
          retry_n = ret_cnt;
        end
      end
      S_FAIL: begin
        if (restart) begin
          state_n = S_RST;
          retry_n = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register
  // on the same edge as the transition.
  always_comb begin
    emif_n = '0;
    unique case (state_n)
      S_IDLE, S_SETTLE: emif_n = '1;
      S_RST, S_FAIL:    emif_n = CHANNEL_MASK;
      default:          emif_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      retry_cnt      <= '0;
      clk_on         <= 1'b0;
      emif_reset_req <= '1;
      sys_reset_n    <= 1'b0;
      fail           <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= (state_n != state) ? '0 : cnt + 25'd1;
      retry_cnt      <= retry_n;
      clk_on         <= 1'b1;
      emif_reset_req <= emif_n;
      sys_reset_n    <= (state_n == S_RUN);
      fail           <= (state_n == S_FAIL);
    end
  end

  assign clkgen_rst_n = {NUM_CLKGEN{clk_on}};
  assign clkgen_oe_n  = {NUM_CLKGEN{~clk_on}};
  assign state_o      = state;

endmodule

// File: tb/tb_emif_bringup_sequencer.sv
// Bench for emif_bringup_sequencer: two instances (full and partial
// channel mask) checked every cycle against a behavioural model.
module tb_emif_bringup_sequencer;

  localparam int CS = 8;
  localparam int RP = 4;
  localparam int CT = 100;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic restart = 1'b0;
  logic [1:0] cal_success = 2'b00;
  logic [1:0] cal_fail = 2'b00;

  logic [1:0] cs_a, oe_a, emif_a, cs_b, oe_b, emif_b;
  logic [2:0] st_a, st_b;
  logic [3:0] rc_a, rc_b;
  logic sys_a, fl_a, sys_b, fl_b;

  int checks = 0;
  int failures = 0;

  int ph [2];
  int left [2];
  int rty [2];
  bit con;
  logic [1:0] hs [2];
  logic [1:0] hf [2];

  always #5 clk = ~clk;

  emif_bringup_sequencer #(
    .NUM_CHANNELS(2), .CHANNEL_MASK(2'b11), .NUM_CLKGEN(2),
    .CLK_SETTLE(CS), .RESET_PULSE(RP), .CAL_TIMEOUT(CT),
    .MAX_RETRIES(MR), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .restart(restart),
    .cal_success(cal_success), .cal_fail(cal_fail),
    .clkgen_rst_n(cs_a), .clkgen_oe_n(oe_a),
    .emif_reset_req(emif_a), .sys_reset_n(sys_a),
    .state_o(st_a), .retry_cnt(rc_a), .fail(fl_a)
  );

  emif_bringup_sequencer #(
    .NUM_CHANNELS(2), .CHANNEL_MASK(2'b01), .NUM_CLKGEN(2),
    .CLK_SETTLE(CS), .RESET_PULSE(RP), .CAL_TIMEOUT(CT),
    .MAX_RETRIES(MR), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .restart(restart),
    .cal_success(cal_success), .cal_fail(cal_fail),
    .clkgen_rst_n(cs_b), .clkgen_oe_n(oe_b),
    .emif_reset_req(emif_b), .sys_reset_n(sys_b),
    .state_o(st_b), .retry_cnt(rc_b), .fail(fl_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] msk(input int i);
    return (i == 0) ? 2'b11 : 2'b01;
  endfunction

  task automatic model_reset();
    con = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0;
      left[i] = 0;
      rty[i] = 0;
      hs[i] = 2'b00;
      hf[i] = 2'b00;
    end
  endtask

  task automatic go_rst(input int i);
    ph[i] = 2;
    left[i] = RP;
  endtask

  task automatic do_retry(input int i);
    if (rty[i] < MR) begin
      rty[i]++;
      go_rst(i);
    end else begin
      ph[i] = 5;
    end
  endtask

  task automatic model_step();
    logic [1:0] so, fo, m, s, f;
    so = hs[1];
    fo = hf[1];
    hs[1] = hs[0];
    hf[1] = hf[0];
    hs[0] = cal_success;
    hf[0] = cal_fail;
    con = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m = msk(i);
      s = so & m;
      f = fo & m;
      case (ph[i])
        0: begin ph[i] = 1; left[i] = CS; end
        1: begin
          left[i]--;
          if (left[i] == 0) go_rst(i);
        end
        2: begin
          left[i]--;
          if (left[i] == 0) begin ph[i] = 3; left[i] = CT; end
        end
        3: begin
          left[i]--;
          if (f != 0 || left[i] == 0) do_retry(i);
          else if (s == m) ph[i] = 4;
        end
        4: begin
          if (restart) begin rty[i] = 0; go_rst(i); end
          else if (s != m || f != 0) do_retry(i);
        end
        default: begin
          if (restart) begin rty[i] = 0; go_rst(i); end
        end
      endcase
    end
  endtask

  task automatic cmp(input int i, input logic [2:0] st,
                     input logic [3:0] rc, input logic fl,
                     input logic sr, input logic [1:0] er,
                     input logic [1:0] cr, input logic [1:0] oe);
    logic [1:0] ee;
    case (ph[i])
      0, 1: ee = 2'b11;
      2, 5: ee = msk(i);
      default: ee = 2'b00;
    endcase
    check($sformatf("state%0d", i), 32'(st), 32'(ph[i]));
    check($sformatf("retry%0d", i), 32'(rc), 32'(rty[i]));
    check($sformatf("fail%0d", i), 32'(fl), 32'(ph[i] == 5));
    check($sformatf("sys%0d", i), 32'(sr), 32'(ph[i] == 4));
    check($sformatf("emif%0d", i), 32'(er), 32'(ee));
    check($sformatf("cgrst%0d", i), 32'(cr), con ? 32'h3 : 32'h0);
    check($sformatf("cgoe%0d", i), 32'(oe), con ? 32'h0 : 32'h3);
  endtask

  task automatic compare_all();
    cmp(0, st_a, rc_a, fl_a, sys_a, emif_a, cs_a, oe_a);
    cmp(1, st_b, rc_b, fl_b, sys_b, emif_b, cs_b, oe_b);
    if (ph[1] >= 2) check("t4_emif1", 32'(emif_b[1]), 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic rst_check(input string tag);
    check({tag, "_st"}, 32'(st_a), 32'h0);
    check({tag, "_cg"}, 32'(cs_a), 32'h0);
    check({tag, "_oe"}, 32'(oe_a), 32'h3);
    check({tag, "_emif"}, 32'(emif_a), 32'h3);
    check({tag, "_sys"}, 32'(sys_a), 32'h0);
    check({tag, "_rc"}, 32'(rc_a), 32'h0);
    check({tag, "_fl"}, 32'(fl_a), 32'h0);
    check({tag, "_stb"}, 32'(st_b), 32'h0);
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    model_reset();
    #1 compare_all();
  endtask

  initial begin
    int mode;
    model_reset();
    @(negedge clk);
    compare_all();
    rst_check("rst");
    run(2);
    reset_n = 1'b1;
    // T1 nominal
    tick();
    check("t1_cg", 32'(cs_a), 32'h3);
    check("t1_st1", 32'(st_a), 32'h1);
    run(11);
    check("t1_emif12", 32'(emif_a), 32'h3);
    tick();
    check("t1_emif13", 32'(emif_a), 32'h0);
    check("t1_st3", 32'(st_a), 32'h3);
    cal_success = 2'b11;
    run(2);
    check("t1_sys_early", 32'(sys_a), 32'h0);
    tick();
    check("t1_sys", 32'(sys_a), 32'h1);
    check("t1_st4", 32'(st_a), 32'h4);
    // T4 masked channel fail in RUN
    cal_fail = 2'b10;
    tick();
    cal_fail = 2'b00;
    run(2);
    check("t4_a_st", 32'(st_a), 32'h2);
    check("t4_b_st", 32'(st_b), 32'h4);
    check("t4_b_rc", 32'(rc_b), 32'h0);
    run(8);
    // T5 loss of calibration in RUN
    cal_success = 2'b10;
    run(3);
    check("t5_sys", 32'(sys_a), 32'h0);
    check("t5_st", 32'(st_a), 32'h2);
    check("t5_rc", 32'(rc_a), 32'h2);
    cal_success = 2'b11;
    run(8);
    check("t5_run", 32'(st_a), 32'h4);
    // T2 fail pulse in CAL_WAIT
    cal_success = 2'b00;
    pulse_restart();
    check("t2_rs_st", 32'(st_a), 32'h2);
    check("t2_rs_rc", 32'(rc_a), 32'h0);
    run(4);
    check("t2_cal", 32'(st_a), 32'h3);
    cal_fail = 2'b10;
    tick();
    cal_fail = 2'b00;
    run(2);
    check("t2_st", 32'(st_a), 32'h2);
    check("t2_rc", 32'(rc_a), 32'h1);
    for (int k = 0; k < 3; k++) begin
      check("t2_emif", 32'(emif_a), 32'h3);
      tick();
    end
    check("t2_emif_hold", 32'(emif_a), 32'h3);
    tick();
    check("t2_emif_rel", 32'(emif_a), 32'h0);
    cal_success = 2'b11;
    run(3);
    check("t2_run", 32'(st_a), 32'h4);
    check("t2_rc_keep", 32'(rc_a), 32'h1);
    // T3 repeated timeouts into FAIL
    cal_success = 2'b00;
    pulse_restart();
    run(311);
    check("t3_pre", 32'(st_a), 32'h3);
    tick();
    check("t3_st", 32'(st_a), 32'h5);
    check("t3_fl", 32'(fl_a), 32'h1);
    check("t3_rc", 32'(rc_a), 32'h2);
    check("t3_sys", 32'(sys_a), 32'h0);
    pulse_restart();
    check("t3_rs_st", 32'(st_a), 32'h2);
    check("t3_rs_rc", 32'(rc_a), 32'h0);
    check("t3_rs_fl", 32'(fl_a), 32'h0);
    // T7 success and fail in the same cycle
    run(4);
    cal_success = 2'b11;
    cal_fail = 2'b01;
    tick();
    cal_success = 2'b00;
    cal_fail = 2'b00;
    run(2);
    check("t7_st", 32'(st_a), 32'h2);
    check("t7_rc", 32'(rc_a), 32'h1);
    // T6 reset during CAL_WAIT and RUN
    run(4);
    check("t6_cal", 32'(st_a), 32'h3);
    assert_reset();
    rst_check("t6_cal");
    run(2);
    reset_n = 1'b1;
    cal_success = 2'b11;
    tick();
    check("t6_settle", 32'(st_a), 32'h1);
    run(13);
    check("t6_run", 32'(st_a), 32'h4);
    assert_reset();
    rst_check("t6_run");
    run(1);
    reset_n = 1'b1;
    // Randomised segments
    for (int n = 0; n < 120; n++) begin
      mode = int'($urandom_range(0, 6));
      case (mode)
        0: begin
          cal_success = 2'b11;
          cal_fail = 2'b00;
          run(int'($urandom_range(1, 40)));
        end
        1: begin
          cal_success = 2'($urandom);
          run(int'($urandom_range(1, 20)));
        end
        2: begin
          cal_success = 2'b00;
          run(int'($urandom_range(50, 320)));
        end
        3: begin
          cal_fail = 2'($urandom_range(1, 3));
          tick();
          cal_fail = 2'b00;
          run(int'($urandom_range(1, 10)));
        end
        4: begin
          pulse_restart();
          run(int'($urandom_range(1, 10)));
        end
        5: begin
          assert_reset();
          run(int'($urandom_range(1, 3)));
          reset_n = 1'b1;
          run(int'($urandom_range(1, 5)));
        end
        default: begin
          cal_success = 2'b11;
          cal_fail = 2'($urandom_range(1, 3));
          tick();
          cal_fail = 2'b00;
          run(int'($urandom_range(1, 10)));
        end
      endcase
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
